// File: rtl/series_adder_arbiter_if.sv
// Bundle of requester, adder and result streams around the series adder arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface series_adder_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s0_data_i;
  logic              s0_vld_i;
  logic              s0_rdy_o;
  logic [DATA_W-1:0] s1_data_i;
  logic              s1_vld_i;
  logic              s1_rdy_o;

  logic [DATA_W-1:0] m_data_o;
  logic              m_vld_o;
  logic              m_rdy_i;

  logic [DATA_W-1:0] r_data_i;
  logic              r_vld_i;
  logic              r_first_i;
  logic              r_last_i;

  logic [DATA_W-1:0] res0_data_o;
  logic              res0_vld_o;
  logic              res0_first_o;
  logic              res0_last_o;
  logic [DATA_W-1:0] res1_data_o;
  logic              res1_vld_o;
  logic              res1_first_o;
  logic              res1_last_o;

  logic              owner_o;
  logic              busy_o;
  logic              err_o;

  modport master (
    input  s0_data_i, s0_vld_i, s1_data_i, s1_vld_i, m_rdy_i,
    input  r_data_i, r_vld_i, r_first_i, r_last_i,
    output s0_rdy_o, s1_rdy_o, m_data_o, m_vld_o,
    output res0_data_o, res0_vld_o, res0_first_o, res0_last_o,
    output res1_data_o, res1_vld_o, res1_first_o, res1_last_o,
    output owner_o, busy_o, err_o
  );

  modport slave (
    output s0_data_i, s0_vld_i, s1_data_i, s1_vld_i, m_rdy_i,
    output r_data_i, r_vld_i, r_first_i, r_last_i,
    input  s0_rdy_o, s1_rdy_o, m_data_o, m_vld_o,
    input  res0_data_o, res0_vld_o, res0_first_o, res0_last_o,
    input  res1_data_o, res1_vld_o, res1_first_o, res1_last_o,
    input  owner_o, busy_o, err_o
  );
endinterface

// File: rtl/series_adder_arbiter.sv
// Round-robin arbiter sharing one series adder between two requesters.
// A job is a header (byte count in [15:0]) followed by 8 words per byte; the
// owner keeps the adder until the adder signals r_last_i or the result wait
// times out. Results are routed back to the owner with one cycle of latency.
module series_adder_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_p,
  series_adder_arbiter_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, WAIT_RES} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [18:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] res0_data_q, res0_data_d, res1_data_q, res1_data_d;
  logic              res0_vld_q, res0_vld_d, res0_first_q, res0_first_d;
  logic              res0_last_q, res0_last_d;
  logic              res1_vld_q, res1_vld_d, res1_first_q, res1_first_d;
  logic              res1_last_q, res1_last_d;

  logic [DATA_W-1:0] own_data;
  logic              own_vld;
  logic              own_rdy;
  logic [15:0]       num_bytes;
  logic              busy;

  // Select the current owner's request stream.
  always_comb begin
    own_data = owner_q ? bus.s1_data_i : bus.s0_data_i;
    own_vld  = owner_q ? bus.s1_vld_i  : bus.s0_vld_i;
  end

  assign num_bytes = own_data[15:0];
  assign busy      = (state_q != IDLE);

  // Job FSM: arbitration, header decode, beat counting and result wait.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    err_d        = 1'b0;
    own_rdy      = 1'b0;
    bus.m_data_o = '0;
    bus.m_vld_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // A result with no job to own it is dropped and flagged.
        if (bus.r_vld_i) err_d = 1'b1;
        if (bus.s0_vld_i && bus.s1_vld_i) begin
          owner_d = ~last_q;
          state_d = HEADER;
        end else if (bus.s0_vld_i) begin
          owner_d = 1'b0;
          state_d = HEADER;
        end else if (bus.s1_vld_i) begin
          owner_d = 1'b1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        bus.m_data_o = own_data;
        if (own_vld && (num_bytes == 16'd0)) begin
          // Empty job: swallow the header without bothering the adder.
          own_rdy = 1'b1;
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          bus.m_vld_o = own_vld;
          own_rdy     = bus.m_rdy_i;
          if (own_vld && bus.m_rdy_i) begin
            cnt_d   = {num_bytes, 3'b000};
            state_d = DATA;
          end
        end
      end
      DATA: begin
        bus.m_data_o = own_data;
        bus.m_vld_o  = own_vld;
        own_rdy      = bus.m_rdy_i;
        if (own_vld && bus.m_rdy_i) begin
          cnt_d = cnt_q - 19'd1;
          if (cnt_q == 19'd1) begin
            tmo_d   = '0;
            state_d = WAIT_RES;
          end
        end
      end
      WAIT_RES: begin
        // Any job end (done or timed out) hands priority to the other side.
        if (bus.r_last_i) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the adder result stream to whichever requester owns the job.
  always_comb begin
    res0_vld_d   = busy & ~owner_q & bus.r_vld_i;
    res0_first_d = busy & ~owner_q & bus.r_first_i;
    res0_last_d  = busy & ~owner_q & bus.r_last_i;
    res0_data_d  = (busy && !owner_q) ? bus.r_data_i : '0;
    res1_vld_d   = busy & owner_q & bus.r_vld_i;
    res1_first_d = busy & owner_q & bus.r_first_i;
    res1_last_d  = busy & owner_q & bus.r_last_i;
    res1_data_d  = (busy && owner_q) ? bus.r_data_i : '0;
  end

  // State, counters and registered result outputs.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      res0_data_q  <= '0;
      res0_vld_q   <= 1'b0;
      res0_first_q <= 1'b0;
      res0_last_q  <= 1'b0;
      res1_data_q  <= '0;
      res1_vld_q   <= 1'b0;
      res1_first_q <= 1'b0;
      res1_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      res0_data_q  <= res0_data_d;
      res0_vld_q   <= res0_vld_d;
      res0_first_q <= res0_first_d;
      res0_last_q  <= res0_last_d;
      res1_data_q  <= res1_data_d;
      res1_vld_q   <= res1_vld_d;
      res1_first_q <= res1_first_d;
      res1_last_q  <= res1_last_d;
    end
  end

  assign bus.s0_rdy_o     = own_rdy & ~owner_q;
  assign bus.s1_rdy_o     = own_rdy & owner_q;
  assign bus.res0_data_o  = res0_data_q;
  assign bus.res0_vld_o   = res0_vld_q;
  assign bus.res0_first_o = res0_first_q;
  assign bus.res0_last_o  = res0_last_q;
  assign bus.res1_data_o  = res1_data_q;
  assign bus.res1_vld_o   = res1_vld_q;
  assign bus.res1_first_o = res1_first_q;
  assign bus.res1_last_o  = res1_last_q;
  assign bus.owner_o      = owner_q;
  assign bus.busy_o       = busy;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_series_adder_arbiter.sv
// Directed bench for series_adder_arbiter: requester words and adder results
// are scoreboarded through queues filled as stimulus is prepared.
module tb_series_adder_arbiter;

  logic clk;
  logic rst_p;

  series_adder_arbiter_if #(.DATA_W(32)) ifc ();

  series_adder_arbiter #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_p(rst_p),
    .bus  (ifc.master)
  );

  typedef struct {
    bit          who;
    logic [31:0] data;
    bit          vld;
    bit          first;
    bit          last;
  } res_t;

  logic [31:0] src0[$];
  logic [31:0] src1[$];
  logic [31:0] exp_m[$];
  res_t        exp_res[$];

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int cyc    = 0;
  bit rdy_toggle = 1'b0;
  bit exp_route  = 1'b0;
  bit exp_owner  = 1'b0;

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] job_word(input bit who, input int nbytes, input int tag, input int i);
    if (i == 0) return {8'(tag), 7'd0, who, 16'(nbytes)};
    return {8'(tag), 7'd0, who, 16'(i) ^ 16'hA500};
  endfunction

  task automatic load_job(input bit who, input int nbytes, input int tag);
    for (int i = 0; i <= 8 * nbytes; i++) begin
      if (who) src1.push_back(job_word(who, nbytes, tag, i));
      else     src0.push_back(job_word(who, nbytes, tag, i));
    end
  endtask

  task automatic expect_job(input bit who, input int nbytes, input int tag);
    for (int i = 0; i <= 8 * nbytes; i++) exp_m.push_back(job_word(who, nbytes, tag, i));
  endtask

  task automatic drive_requesters();
    ifc.m_rdy_i   = rdy_toggle ? cyc[0] : 1'b1;
    ifc.s0_vld_i  = (src0.size() != 0);
    ifc.s0_data_i = (src0.size() != 0) ? src0[0] : '0;
    ifc.s1_vld_i  = (src1.size() != 0);
    ifc.s1_data_i = (src1.size() != 0) ? src1[0] : '0;
  endtask

  task automatic present();
    drive_requesters();
    #1;
  endtask

  // One clock of stimulus with scoreboard checks on both streams.
  task automatic apply_stimulus(input bit rv = 0, input bit rf = 0, input bit rl = 0,
                                input logic [31:0] rd = '0);
    bit   acc0, acc1;
    res_t r;
    drive_requesters();
    ifc.r_vld_i   = rv;
    ifc.r_first_i = rf;
    ifc.r_last_i  = rl;
    ifc.r_data_i  = rd;
    #1;
    if (ifc.m_vld_o && ifc.m_rdy_i) begin
      xfers++;
      if (exp_m.size() == 0) check_bit("m_unexpected", ifc.m_vld_o, 1'b0);
      else check_output("m_data", ifc.m_data_o, exp_m.pop_front());
    end
    if (exp_route && (rv || rf || rl)) begin
      r.who = exp_owner; r.data = rd; r.vld = rv; r.first = rf; r.last = rl;
      exp_res.push_back(r);
    end
    acc0 = ifc.s0_vld_i && ifc.s0_rdy_o;
    acc1 = ifc.s1_vld_i && ifc.s1_rdy_o;
    @(posedge clk);
    #1;
    cyc++;
    if (acc0) void'(src0.pop_front());
    if (acc1) void'(src1.pop_front());
    ifc.r_vld_i = 1'b0; ifc.r_first_i = 1'b0; ifc.r_last_i = 1'b0; ifc.r_data_i = '0;
    if (exp_res.size() != 0) begin
      r = exp_res.pop_front();
      if (!r.who) begin
        check_bit("res0_vld", ifc.res0_vld_o, r.vld);
        check_output("res0_data", ifc.res0_data_o, r.data);
        check_bit("res0_first", ifc.res0_first_o, r.first);
        check_bit("res0_last", ifc.res0_last_o, r.last);
        check_output("res1_quiet", {29'd0, ifc.res1_vld_o, ifc.res1_first_o, ifc.res1_last_o}, 32'd0);
      end else begin
        check_bit("res1_vld", ifc.res1_vld_o, r.vld);
        check_output("res1_data", ifc.res1_data_o, r.data);
        check_bit("res1_first", ifc.res1_first_o, r.first);
        check_bit("res1_last", ifc.res1_last_o, r.last);
        check_output("res0_quiet", {29'd0, ifc.res0_vld_o, ifc.res0_first_o, ifc.res0_last_o}, 32'd0);
      end
    end else begin
      check_output("res_silent", {26'd0, ifc.res0_vld_o, ifc.res0_first_o, ifc.res0_last_o,
                                  ifc.res1_vld_o, ifc.res1_first_o, ifc.res1_last_o}, 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    src0.delete(); src1.delete(); exp_m.delete(); exp_res.delete();
    exp_route = 1'b0;
    ifc.s0_vld_i = 1'b0; ifc.s1_vld_i = 1'b0; ifc.s0_data_i = '0; ifc.s1_data_i = '0;
    ifc.m_rdy_i = 1'b1; ifc.r_vld_i = 1'b0; ifc.r_first_i = 1'b0; ifc.r_last_i = 1'b0;
    ifc.r_data_i = '0;
    #1;
    check_bit("rst_busy", ifc.busy_o, 1'b0);
    check_bit("rst_owner", ifc.owner_o, 1'b0);
    check_bit("rst_err", ifc.err_o, 1'b0);
    check_bit("rst_m_vld", ifc.m_vld_o, 1'b0);
    check_output("rst_res", {26'd0, ifc.res0_vld_o, ifc.res0_first_o, ifc.res0_last_o,
                             ifc.res1_vld_o, ifc.res1_first_o, ifc.res1_last_o}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_p = 1'b0;
  endtask

  // Drain the expected forwarded words of the current job, bounded by budget.
  task automatic run_job(input bit who, input int budget);
    int n = 0;
    exp_owner = who;
    exp_route = 1'b1;
    while (exp_m.size() != 0 && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output("job_drained", 32'(exp_m.size()), 32'd0);
    check_bit("job_owner", ifc.owner_o, who);
    check_bit("job_busy_wait", ifc.busy_o, 1'b1);
  endtask

  // Two result beats, the second carrying r_last_i, which ends the job.
  task automatic finish_job(input logic [31:0] tag);
    apply_stimulus(1'b1, 1'b1, 1'b0, tag ^ 32'h0000_1111);
    apply_stimulus(1'b1, 1'b0, 1'b1, tag ^ 32'h0000_2222);
    check_bit("job_released", ifc.busy_o, 1'b0);
    check_bit("job_no_err", ifc.err_o, 1'b0);
    exp_route = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int n;
    do_reset();

    // Single requester, one-byte job, with an r_last_i mid-DATA that must not end it.
    load_job(1'b0, 1, 8'h21);
    expect_job(1'b0, 1, 8'h21);
    exp_owner = 1'b0;
    exp_route = 1'b1;
    repeat (3) apply_stimulus();
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0BAD_0001);
    check_bit("data_last_ignored", ifc.busy_o, 1'b1);
    run_job(1'b0, 40);
    finish_job(32'hA000_0000);

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    do_reset();
    load_job(1'b0, 1, 8'h10);
    load_job(1'b0, 1, 8'h12);
    load_job(1'b1, 1, 8'h11);
    load_job(1'b1, 1, 8'h13);
    for (int j = 0; j < 4; j++) begin
      expect_job(1'(j % 2), 1, 8'h10 + j);
      run_job(1'(j % 2), 40);
      finish_job(32'hB000_0000 + 32'(j));
    end

    // Zero-length header from requester 1.
    src1.push_back(job_word(1'b1, 0, 8'h30, 0));
    apply_stimulus();
    present();
    check_bit("zero_s1_rdy", ifc.s1_rdy_o, 1'b1);
    check_bit("zero_s0_rdy", ifc.s0_rdy_o, 1'b0);
    check_bit("zero_m_vld", ifc.m_vld_o, 1'b0);
    check_bit("zero_owner", ifc.owner_o, 1'b1);
    apply_stimulus();
    check_bit("zero_err", ifc.err_o, 1'b1);
    check_bit("zero_idle", ifc.busy_o, 1'b0);
    apply_stimulus();
    check_bit("zero_err_pulse", ifc.err_o, 1'b0);

    // Result arriving while idle is dropped and flagged.
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check_bit("idle_res_err", ifc.err_o, 1'b1);
    apply_stimulus();
    check_bit("idle_res_err_pulse", ifc.err_o, 1'b0);

    // Two-byte job with adder ready toggling.
    xfers = 0;
    rdy_toggle = 1'b1;
    load_job(1'b0, 2, 8'h40);
    expect_job(1'b0, 2, 8'h40);
    run_job(1'b0, 100);
    rdy_toggle = 1'b0;
    check_output("toggle_xfers", 32'(xfers), 32'd17);
    check_output("toggle_src_empty", 32'(src0.size()), 32'd0);
    finish_job(32'hC000_0000);

    // Result wait timeout with requester 1 pending.
    load_job(1'b0, 1, 8'h50);
    expect_job(1'b0, 1, 8'h50);
    run_job(1'b0, 40);
    load_job(1'b1, 1, 8'h51);
    n = 0;
    while (ifc.busy_o && n < 40) begin
      apply_stimulus();
      n++;
    end
    check_output("timeout_cycles", 32'(n), 32'd16);
    check_bit("timeout_err", ifc.err_o, 1'b1);
    check_bit("timeout_idle", ifc.busy_o, 1'b0);
    exp_route = 1'b0;
    expect_job(1'b1, 1, 8'h51);
    apply_stimulus();
    check_bit("timeout_next_owner", ifc.owner_o, 1'b1);
    check_bit("timeout_next_busy", ifc.busy_o, 1'b1);
    check_bit("timeout_err_pulse", ifc.err_o, 1'b0);
    run_job(1'b1, 40);
    finish_job(32'hD000_0000);

    // Asynchronous reset in the middle of DATA, then a fresh job.
    load_job(1'b0, 2, 8'h60);
    expect_job(1'b0, 2, 8'h60);
    exp_owner = 1'b0;
    exp_route = 1'b1;
    repeat (5) apply_stimulus();
    check_bit("pre_rst_busy", ifc.busy_o, 1'b1);
    rst_p = 1'b1;
    #1;
    check_bit("async_busy", ifc.busy_o, 1'b0);
    check_bit("async_owner", ifc.owner_o, 1'b0);
    check_bit("async_m_vld", ifc.m_vld_o, 1'b0);
    check_bit("async_s0_rdy", ifc.s0_rdy_o, 1'b0);
    check_bit("async_err", ifc.err_o, 1'b0);
    check_bit("async_res0_vld", ifc.res0_vld_o, 1'b0);
    src0.delete(); exp_m.delete(); exp_res.delete();
    exp_route = 1'b0;
    apply_stimulus();
    apply_stimulus();
    rst_p = 1'b0;
    load_job(1'b0, 2, 8'h70);
    expect_job(1'b0, 2, 8'h70);
    run_job(1'b0, 60);
    finish_job(32'hE000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
